fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the rv32i pipeline and the producer side of the IF/ID stage register. It owns the PC and runs the request/response handshake with instruction memory. It presents each fetched instruction with its PC and pre-sliced opcode, funct3 and funct7 fields, and pulses `if_load` into the IF/ID register's `load` input. It honours downstream stalls and EX-stage redirects, discarding any response that is in flight when a redirect arrives.

## Interface
Parameters:
- `RESET_PC`, default 32'h4000_0060: PC fetched first after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_address`  out  32  fetch address; stable while `imem_read`=1 until `imem_resp`.
- `imem_read`  out  1  fetch request.
- `imem_rdata`  in  32  instruction word; valid only when `imem_resp`=1.
- `imem_resp`  in  1  one-cycle response strobe.
- `stall`  in  1  IF/ID register must not load this cycle.
- `redirect`  in  1  taken branch or jump from EX.
- `redirect_pc`  in  32  new PC; sampled only when `redirect`=1.
- `pc_if`  out  32  PC of the presented instruction (rv32i_word).
- `instr_if`  out  32  presented instruction (rv32i_word).
- `opcode_if`  out  7  `instr_if[6:0]` (rv32i_opcode).
- `funct3_if`  out  3  `instr_if[14:12]`.
- `funct7_if`  out  7  `instr_if[31:25]`.
- `if_load`  out  1  drives IF/ID `load`; 1 means the outputs above are captured this cycle.

## Operation
Registers:
- `pc`: address of the outstanding or next fetch.
- `buf_instr`: held instruction.
- `pend_pc`: pending redirect target.
- `state`: one of FETCH, HOLD, DISCARD.

The field outputs are combinational slices of `instr_if`.

FETCH (`imem_read`=1, `imem_address`=`pc`, `instr_if`=`imem_rdata`, `pc_if`=`pc`):
- `redirect`: `if_load`=0, and any response this cycle is dropped.
  - If `imem_resp`=1: `pc`<=`redirect_pc`, stay in FETCH.
  - If `imem_resp`=0: `pend_pc`<=`redirect_pc`, go to DISCARD.
- `imem_resp` with `!stall`: `if_load`=1, `pc`<=`pc`+4, stay in FETCH; the next request issues the following cycle.
- `imem_resp` with `stall`: `if_load`=0, `buf_instr`<=`imem_rdata`, go to HOLD.
- Otherwise `if_load`=0.

HOLD (`imem_read`=0, `instr_if`=`buf_instr`, `pc_if`=`pc`):
- `redirect`: drop the buffer, `pc`<=`redirect_pc`, go to FETCH.
- `!stall`: `if_load`=1, `pc`<=`pc`+4, go to FETCH.
- Otherwise hold with `if_load`=0.

DISCARD (`imem_read`=1, `imem_address`=`pc`, `if_load`=0):
- A `redirect` in this state overwrites `pend_pc`; the last target wins.
- On `imem_resp`: drop the data, `pc`<=`pend_pc` (or `redirect_pc` if `redirect` is asserted the same cycle), go to FETCH.

Arithmetic and priority rules:
- PC increment is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Alignment bits are not checked.
- Priority: `rst` > `redirect` > `imem_resp`/`stall`.

## Timing
- During `rst` and in the cycle after release:
  - Outputs: `imem_read`=0, `if_load`=0, `instr_if`=0, `pc_if`=`RESET_PC`, `imem_address`=`RESET_PC`.
  - State: `state`=FETCH, `pc`=`RESET_PC`, `buf_instr`=0, `pend_pc`=0.
- `imem_read` first rises in the second cycle after `rst` deasserts.
- Zero-cycle pass-through: a response arriving with `!stall` is loaded into IF/ID in the same cycle.
- Back-to-back single-cycle memory sustains one `if_load` per cycle.
- After a redirect the first new request issues the next cycle from FETCH or HOLD. From DISCARD it issues the cycle after the discarded response.
- `imem_address` never changes while a request is outstanding.
- `rst` asserted mid-request abandons the request. The core's memory model must tolerate an abandoned read.

## Configuration
`FETCH_FLUSH_BUBBLE_EN`:
- Defined: on any cycle with `redirect`=1 (and `rst`=0), `if_load`=1 regardless of `stall`. The presented values are `instr_if`=32'h0000_0013 (addi x0,x0,0), `pc_if`=0, and decoded fields to match. This flushes the wrong-path instruction out of IF/ID.
- Undefined: `if_load`=0 on redirect cycles, and the hazard unit is responsible for squashing IF/ID.

## Test plan
- Reset, single-cycle memory returning 0x00000013 every cycle, `stall`=0 -> first `imem_address`=0x40000060; consecutive `if_load` pulses with `pc_if` 0x40000060, 0x40000064, 0x40000068.
- Response 0x00A00093 arrives during `stall`=1 held 3 cycles -> `imem_read`=0 and `if_load`=0 for 3 cycles with `instr_if`=0x00A00093 held; `if_load`=1 on the cycle `stall` drops; the next fetch is at `pc`+4.
- 3-cycle memory latency; `redirect` to 0x40000100 in the first wait cycle -> address held until the response, data dropped (no `if_load`), next request at 0x40000100.
- Two redirects (0x40000200 then 0x40000300) during DISCARD -> fetch resumes at 0x40000300.
- `redirect` coincident with `imem_resp` -> no `if_load` (macro off), or a bubble load with `instr_if`=0x00000013 (macro on); next address = `redirect_pc`.
- `rst` pulsed mid-request, then PC wrap from a redirect to 0xFFFFFFFC -> all outputs back to reset values, refetch at 0x40000060; after the second redirect the fetch after 0xFFFFFFFC is 0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction-fetch stage, producer side of the IF/ID register.
// Owns the PC and runs the imem request/response handshake. It honours downstream
// stalls, and it drops an in-flight response when EX redirects the fetch stream.
// Optional feature macro: FETCH_FLUSH_BUBBLE_EN. When defined, each redirect cycle
// loads an addi x0,x0,0 bubble into IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic [6:0]  opcode_if,
  output logic [2:0]  funct3_if,
  output logic [6:0]  funct7_if,
  output logic        if_load
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

`ifdef FETCH_FLUSH_BUBBLE_EN
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] pend_pc;
  // run stays low through the first cycle after reset release, which delays the
  // first request to the second cycle after rst deasserts.
  logic        run;
  logic        active;

  function automatic logic [31:0] pc_next(input logic [31:0] p);
    return p + 32'd4;  // wraps modulo 2^32
  endfunction

  assign active = run && !rst;

  // Output decode from registered state, with same-cycle pass-through of imem data.
  always_comb begin
    imem_read    = active && (state != HOLD);
    imem_address = rst ? RESET_PC : pc;
    pc_if        = rst ? RESET_PC : pc;
    instr_if     = 32'h0;
    if_load      = 1'b0;
    if (active) begin
      instr_if = (state == HOLD) ? buf_instr : imem_rdata;
      if (!redirect) begin
        case (state)
          FETCH:   if_load = imem_resp && !stall;
          HOLD:    if_load = !stall;
          default: if_load = 1'b0;
        endcase
      end
`ifdef FETCH_FLUSH_BUBBLE_EN
      if (redirect) begin
        if_load  = 1'b1;
        instr_if = NOP_INSTR;
        pc_if    = 32'h0;
      end
`endif
    end
  end

  assign opcode_if = instr_if[6:0];
  assign funct3_if = instr_if[14:12];
  assign funct7_if = instr_if[31:25];

  // Fetch FSM. Priority is reset, then redirect, then response/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      buf_instr <= 32'h0;
      pend_pc   <= 32'h0;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        case (state)
          FETCH: begin
            if (redirect) begin
              if (imem_resp) begin
                pc <= redirect_pc;
              end else begin
                pend_pc <= redirect_pc;
                state   <= DISCARD;
              end
            end else if (imem_resp) begin
              if (!stall) begin
                pc <= pc_next(pc);
              end else begin
                buf_instr <= imem_rdata;
                state     <= HOLD;
              end
            end
          end
          HOLD: begin
            if (redirect) begin
              pc    <= redirect_pc;
              state <= FETCH;
            end else if (!stall) begin
              pc    <= pc_next(pc);
              state <= FETCH;
            end
          end
          DISCARD: begin
            if (imem_resp) begin
              pc    <= redirect ? redirect_pc : pend_pc;
              state <= FETCH;
            end else if (redirect) begin
              pend_pc <= redirect_pc;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule
